fpu_issue_ctrl: RTL and testbench



---
 rtl/fpu_issue_pkg.sv | 54 +++++
 rtl/fpu_issue_decode.sv | 106 ++++++++++
 rtl/fpu_issue_ctrl.sv | 132 +++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_issue_pkg.sv
// fpu_issue_pkg: shared types and encodings for the half-precision FPU issue sequencer.
// Holds the FSM state enum, the OP-FP and fused multiply-add major opcodes,
// the OP-FP funct5 values, the bit positions inside the sfpu_op one-hot and
// the half-precision fmt field value.
package fpu_issue_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, WAIT, DONE} state_t;

    localparam logic [6:0] OPC_OPFP   = 7'b1010011;
    localparam logic [6:0] OPC_FMADD  = 7'b1000011;
    localparam logic [6:0] OPC_FMSUB  = 7'b1000111;
    localparam logic [6:0] OPC_FNMSUB = 7'b1001011;
    localparam logic [6:0] OPC_FNMADD = 7'b1001111;

    localparam logic [4:0] F5_ADD    = 5'b00000;
    localparam logic [4:0] F5_SUB    = 5'b00001;
    localparam logic [4:0] F5_MUL    = 5'b00010;
    localparam logic [4:0] F5_DIV    = 5'b00011;
    localparam logic [4:0] F5_SGNJ   = 5'b00100;
    localparam logic [4:0] F5_MINMAX = 5'b00101;
    localparam logic [4:0] F5_SQRT   = 5'b01011;
    localparam logic [4:0] F5_CMP    = 5'b10100;
    localparam logic [4:0] F5_CVT_WH = 5'b11000;
    localparam logic [4:0] F5_CVT_HW = 5'b11010;
    localparam logic [4:0] F5_MV_XH  = 5'b11100;
    localparam logic [4:0] F5_MV_HX  = 5'b11110;

    localparam int B_ADD    = 0;
    localparam int B_SUB    = 1;
    localparam int B_MUL    = 2;
    localparam int B_DIV    = 3;
    localparam int B_SQRT   = 4;
    localparam int B_MIN    = 5;
    localparam int B_MAX    = 6;
    localparam int B_MV_XH  = 7;
    localparam int B_MV_HX  = 8;
    localparam int B_FEQ    = 9;
    localparam int B_FLT    = 10;
    localparam int B_FLE    = 11;
    localparam int B_FMADD  = 12;
    localparam int B_FMSUB  = 13;
    localparam int B_CVT_WH = 14;
    localparam int B_CVT_HW = 15;
    localparam int B_FNMSUB = 16;
    localparam int B_FNMADD = 17;
    localparam int B_SGNJ   = 18;
    localparam int B_SGNJN  = 19;
    localparam int B_SGNJX  = 20;
    localparam int B_UNS    = 22;
    localparam int B_SGN    = 23;

    localparam logic [1:0] FMT_H = 2'b10;

endpackage

// File: rtl/fpu_issue_decode.sv
// fpu_issue_decode: combinational Zfh instruction decoder for the FPU issue sequencer.
// Ports: instr (32-bit instruction word), csr_frm (dynamic rounding mode)
//        -> sfpu_op (one-hot FPU opcode), frm (resolved rounding mode),
//           is_int (result targets the integer file), illegal (not decodable).
// Optional: FPU_DIVSQRT_EN makes fdiv.h / fsqrt.h legal; otherwise they decode as illegal.
module fpu_issue_decode
    import fpu_issue_pkg::*;
#(
    parameter int OPW = 24
) (
    input  logic [31:0]    instr,
    input  logic [2:0]     csr_frm,
    output logic [OPW-1:0] sfpu_op,
    output logic [2:0]     frm,
    output logic           is_int,
    output logic           illegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rs2;
    logic [4:0] funct5;
    logic [1:0] fmt;
    logic [2:0] rm;
    logic       uses_rm;
    logic       bad;
    logic       unused_fields;

    assign opcode        = instr[6:0];
    assign funct3        = instr[14:12];
    assign rs2           = instr[24:20];
    assign fmt           = instr[26:25];
    assign funct5        = instr[31:27];
    assign unused_fields = ^{instr[19:15], instr[11:7]};

    // funct3 = 111 is the "dynamic" encoding and defers to the CSR value
    assign rm = (funct3 == 3'b111) ? csr_frm : funct3;

    always_comb begin
        sfpu_op = '0;
        is_int  = 1'b0;
        uses_rm = 1'b0;
        bad     = 1'b0;
        if (opcode == OPC_OPFP) begin
            case (funct5)
                F5_ADD: begin sfpu_op[B_ADD] = 1'b1; uses_rm = 1'b1; end
                F5_SUB: begin sfpu_op[B_SUB] = 1'b1; uses_rm = 1'b1; end
                F5_MUL: begin sfpu_op[B_MUL] = 1'b1; uses_rm = 1'b1; end
`ifdef FPU_DIVSQRT_EN
                F5_DIV:  sfpu_op[B_DIV] = 1'b1;
                F5_SQRT: begin sfpu_op[B_SQRT] = 1'b1; bad = (rs2 != 5'd0); end
`endif
                F5_SGNJ: case (funct3)
                    3'b000:  sfpu_op[B_SGNJ]  = 1'b1;
                    3'b001:  sfpu_op[B_SGNJN] = 1'b1;
                    3'b010:  sfpu_op[B_SGNJX] = 1'b1;
                    default: bad = 1'b1;
                endcase
                F5_MINMAX: case (funct3)
                    3'b000:  sfpu_op[B_MIN] = 1'b1;
                    3'b001:  sfpu_op[B_MAX] = 1'b1;
                    default: bad = 1'b1;
                endcase
                F5_CMP: begin
                    is_int = 1'b1;
                    case (funct3)
                        3'b000:  sfpu_op[B_FLE] = 1'b1;
                        3'b001:  sfpu_op[B_FLT] = 1'b1;
                        3'b010:  sfpu_op[B_FEQ] = 1'b1;
                        default: bad = 1'b1;
                    endcase
                end
                // conversions carry a second hot bit for signed (rs2=0) / unsigned (rs2=1)
                F5_CVT_WH, F5_CVT_HW: begin
                    uses_rm = 1'b1;
                    is_int  = (funct5 == F5_CVT_WH);
                    sfpu_op[B_CVT_WH] = (funct5 == F5_CVT_WH);
                    sfpu_op[B_CVT_HW] = (funct5 == F5_CVT_HW);
                    sfpu_op[B_SGN]    = (rs2 == 5'd0);
                    sfpu_op[B_UNS]    = (rs2 == 5'd1);
                    bad               = (rs2 > 5'd1);
                end
                F5_MV_XH: begin
                    is_int = 1'b1;
                    sfpu_op[B_MV_XH] = 1'b1;
                    bad    = (funct3 != 3'b000);
                end
                F5_MV_HX: sfpu_op[B_MV_HX] = 1'b1;
                default:  bad = 1'b1;
            endcase
        end else begin
            uses_rm = 1'b1;
            case (opcode)
                OPC_FMADD:  sfpu_op[B_FMADD]  = 1'b1;
                OPC_FMSUB:  sfpu_op[B_FMSUB]  = 1'b1;
                OPC_FNMSUB: sfpu_op[B_FNMSUB] = 1'b1;
                OPC_FNMADD: sfpu_op[B_FNMADD] = 1'b1;
                default:    bad = 1'b1;
            endcase
        end
    end

    assign frm     = uses_rm ? rm : funct3;
    assign illegal = bad || (fmt != FMT_H) || (uses_rm && rm > 3'd4);

endmodule

// File: rtl/fpu_issue_ctrl.sv
// fpu_issue_ctrl: issue/writeback sequencer in front of the half-precision FPU.
// Ports: clk, rst_l (async active-low);
//        in_valid/in_ready/in_instr/in_rs1..3_fp/in_rs1_int : instruction intake;
//        csr_frm, csr_fflags_clr, fflags                   : rounding mode / sticky flags;
//        fpu_op_a/b/c/int, fpu_frm, fpu_sfpu_op, fpu_vfpu_op: FPU drive (op pulses one cycle);
//        fpu_resultant, fpu_result_rd, fpu_s_flags          : FPU results, valid the cycle after issue;
//        wb_valid/wb_ready/wb_rd/wb_is_int/wb_data/wb_flags/wb_illegal : held writeback.
// Optional: FPU_DIVSQRT_EN enables fdiv.h / fsqrt.h in the decoder.
module fpu_issue_ctrl
    import fpu_issue_pkg::*;
#(
    parameter int STD   = 15,
    parameter int INT_W = 32,
    parameter int OPW   = 24
) (
    input  logic             clk,
    input  logic             rst_l,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [STD:0]     in_rs1_fp,
    input  logic [STD:0]     in_rs2_fp,
    input  logic [STD:0]     in_rs3_fp,
    input  logic [INT_W-1:0] in_rs1_int,
    input  logic [2:0]       csr_frm,
    input  logic             csr_fflags_clr,
    output logic [STD:0]     fpu_op_a,
    output logic [STD:0]     fpu_op_b,
    output logic [STD:0]     fpu_op_c,
    output logic [INT_W-1:0] fpu_op_int,
    output logic [2:0]       fpu_frm,
    output logic [OPW-1:0]   fpu_sfpu_op,
    output logic [27:0]      fpu_vfpu_op,
    input  logic [STD:0]     fpu_resultant,
    input  logic [INT_W-1:0] fpu_result_rd,
    input  logic [4:0]       fpu_s_flags,
    output logic             wb_valid,
    input  logic             wb_ready,
    output logic [4:0]       wb_rd,
    output logic             wb_is_int,
    output logic [INT_W-1:0] wb_data,
    output logic [4:0]       wb_flags,
    output logic             wb_illegal,
    output logic [4:0]       fflags
);

    state_t         state;
    state_t         state_nx;
    logic [OPW-1:0] op_q;
    logic [OPW-1:0] dec_op;
    logic [2:0]     dec_frm;
    logic           dec_int;
    logic           dec_ill;
    logic           accept;

    fpu_issue_decode #(.OPW(OPW)) u_decode (
        .instr   (in_instr),
        .csr_frm (csr_frm),
        .sfpu_op (dec_op),
        .frm     (dec_frm),
        .is_int  (dec_int),
        .illegal (dec_ill)
    );

    assign fpu_vfpu_op = '0;
    assign accept      = (state == IDLE) && in_valid;

    always_comb begin
        state_nx    = state;
        in_ready    = 1'b0;
        wb_valid    = 1'b0;
        fpu_sfpu_op = '0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nx = dec_ill ? DONE : EXEC;
            end
            EXEC: begin
                fpu_sfpu_op = op_q;
                state_nx    = WAIT;
            end
            WAIT: state_nx = DONE;
            DONE: begin
                wb_valid = 1'b1;
                if (wb_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state      <= IDLE;
            op_q       <= '0;
            fpu_op_a   <= '0;
            fpu_op_b   <= '0;
            fpu_op_c   <= '0;
            fpu_op_int <= '0;
            fpu_frm    <= '0;
            wb_rd      <= '0;
            wb_is_int  <= 1'b0;
            wb_illegal <= 1'b0;
            wb_data    <= '0;
            wb_flags   <= '0;
            fflags     <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                op_q       <= dec_op;
                fpu_op_a   <= in_rs1_fp;
                fpu_op_b   <= in_rs2_fp;
                fpu_op_c   <= in_rs3_fp;
                fpu_op_int <= in_rs1_int;
                fpu_frm    <= dec_frm;
                wb_rd      <= in_instr[11:7];
                wb_is_int  <= dec_int && !dec_ill;
                wb_illegal <= dec_ill;
                wb_data    <= '0;
                wb_flags   <= '0;
            end
            // FPU result is registered inside the FPU, so it is captured on the WAIT edge
            if (state == WAIT) begin
                wb_data  <= wb_is_int ? fpu_result_rd : {{(INT_W-STD-1){1'b0}}, fpu_resultant};
                wb_flags <= fpu_s_flags;
                fflags   <= csr_fflags_clr ? fpu_s_flags : (fflags | fpu_s_flags);
            end else if (csr_fflags_clr) begin
                fflags <= '0;
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// tb_fpu_issue_ctrl: directed self-checking bench for fpu_issue_ctrl; the bench plays the FPU.
module tb_fpu_issue_ctrl;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [15:0] in_rs1_fp = '0;
    logic [15:0] in_rs2_fp = '0;
    logic [15:0] in_rs3_fp = '0;
    logic [31:0] in_rs1_int = '0;
    logic [2:0]  csr_frm = '0;
    logic        csr_fflags_clr = 1'b0;
    logic [15:0] fpu_op_a;
    logic [15:0] fpu_op_b;
    logic [15:0] fpu_op_c;
    logic [31:0] fpu_op_int;
    logic [2:0]  fpu_frm;
    logic [23:0] fpu_sfpu_op;
    logic [27:0] fpu_vfpu_op;
    logic [15:0] fpu_resultant = '0;
    logic [31:0] fpu_result_rd = '0;
    logic [4:0]  fpu_s_flags = '0;
    logic        wb_valid;
    logic        wb_ready = 1'b0;
    logic [4:0]  wb_rd;
    logic        wb_is_int;
    logic [31:0] wb_data;
    logic [4:0]  wb_flags;
    logic        wb_illegal;
    logic [4:0]  fflags;

    int n_vec = 0;
    int n_err = 0;

    fpu_issue_ctrl dut (
        .clk            (clk),
        .rst_l          (rst_l),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_instr       (in_instr),
        .in_rs1_fp      (in_rs1_fp),
        .in_rs2_fp      (in_rs2_fp),
        .in_rs3_fp      (in_rs3_fp),
        .in_rs1_int     (in_rs1_int),
        .csr_frm        (csr_frm),
        .csr_fflags_clr (csr_fflags_clr),
        .fpu_op_a       (fpu_op_a),
        .fpu_op_b       (fpu_op_b),
        .fpu_op_c       (fpu_op_c),
        .fpu_op_int     (fpu_op_int),
        .fpu_frm        (fpu_frm),
        .fpu_sfpu_op    (fpu_sfpu_op),
        .fpu_vfpu_op    (fpu_vfpu_op),
        .fpu_resultant  (fpu_resultant),
        .fpu_result_rd  (fpu_result_rd),
        .fpu_s_flags    (fpu_s_flags),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_rd          (wb_rd),
        .wb_is_int      (wb_is_int),
        .wb_data        (wb_data),
        .wb_flags       (wb_flags),
        .wb_illegal     (wb_illegal),
        .fflags         (fflags)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [31:0] i, input logic [15:0] a, input logic [15:0] b,
                          input logic [15:0] c, input logic [31:0] x);
        int n = 0;
        while (!in_ready && n < 20) begin
            step;
            n++;
        end
        if (!in_ready) chk("in_ready_timeout", {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        in_instr   = i;
        in_rs1_fp  = a;
        in_rs2_fp  = b;
        in_rs3_fp  = c;
        in_rs1_int = x;
        step;
        in_valid = 1'b0;
    endtask

    task automatic retire;
        wb_ready = 1'b1;
        step;
        wb_ready = 1'b0;
    endtask

    function automatic logic [31:0] opfp(input logic [4:0] f5, input logic [4:0] rs2,
                                         input logic [2:0] f3, input logic [4:0] rd);
        return {f5, 2'b10, rs2, 5'd1, f3, rd, 7'b1010011};
    endfunction

    initial begin
        #12;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_fflags", {27'd0, fflags}, 32'd0);
        chk("rst_sfpu", {8'd0, fpu_sfpu_op}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        rst_l = 1'b1;
        step;

        // fadd.h rd=5 rm=000: 1.0 + 2.0 = 3.0
        fpu_resultant = 16'h4200;
        fpu_s_flags   = 5'b00000;
        accept(opfp(5'b00000, 5'd2, 3'b000, 5'd5), 16'h3C00, 16'h4000, 16'h0000, 32'd0);
        chk("add_exec_op", {8'd0, fpu_sfpu_op}, 32'h000001);
        chk("add_exec_a", {16'd0, fpu_op_a}, 32'h3C00);
        chk("add_exec_b", {16'd0, fpu_op_b}, 32'h4000);
        chk("add_exec_frm", {29'd0, fpu_frm}, 32'd0);
        chk("add_exec_rdy", {31'd0, in_ready}, 32'd0);
        step;
        chk("add_wait_op", {8'd0, fpu_sfpu_op}, 32'd0);
        chk("add_wait_vld", {31'd0, wb_valid}, 32'd0);
        step;
        chk("add_done_vld", {31'd0, wb_valid}, 32'd1);
        chk("add_data", wb_data, 32'h00004200);
        chk("add_is_int", {31'd0, wb_is_int}, 32'd0);
        chk("add_rd", {27'd0, wb_rd}, 32'd5);
        chk("add_ill", {31'd0, wb_illegal}, 32'd0);
        retire;
        chk("add_back_idle", {31'd0, in_ready}, 32'd1);

        // fmadd.h with dynamic rm, csr_frm=001
        csr_frm = 3'b001;
        accept({5'd3, 2'b10, 5'd2, 5'd1, 3'b111, 5'd9, 7'b1000011}, 16'h3C00, 16'h3C00, 16'h3C00, 32'd0);
        chk("fma_op", {8'd0, fpu_sfpu_op}, 32'h001000);
        chk("fma_frm", {29'd0, fpu_frm}, 32'd1);
        chk("fma_c", {16'd0, fpu_op_c}, 32'h3C00);
        step;
        step;
        chk("fma_vld", {31'd0, wb_valid}, 32'd1);
        retire;

        // fmadd.h with dynamic rm resolving to 101: illegal, no FPU pulse
        csr_frm = 3'b101;
        accept({5'd3, 2'b10, 5'd2, 5'd1, 3'b111, 5'd9, 7'b1000011}, 16'h3C00, 16'h3C00, 16'h3C00, 32'd0);
        chk("badrm_vld", {31'd0, wb_valid}, 32'd1);
        chk("badrm_ill", {31'd0, wb_illegal}, 32'd1);
        chk("badrm_op", {8'd0, fpu_sfpu_op}, 32'd0);
        chk("badrm_flags", {27'd0, wb_flags}, 32'd0);
        retire;
        csr_frm = 3'b000;

        // feq.h returns 1 into the integer file; held for 5 cycles with wb_ready low
        fpu_result_rd = 32'd1;
        accept(opfp(5'b10100, 5'd2, 3'b010, 5'd11), 16'h3C00, 16'h3C00, 16'h0000, 32'd0);
        chk("feq_op", {8'd0, fpu_sfpu_op}, 32'h000200);
        step;
        step;
        fpu_result_rd = 32'hDEAD_BEEF;
        chk("feq_is_int", {31'd0, wb_is_int}, 32'd1);
        chk("feq_data", wb_data, 32'h00000001);
        for (int i = 0; i < 5; i++) begin
            step;
            chk("hold_vld", {31'd0, wb_valid}, 32'd1);
            chk("hold_data", wb_data, 32'h00000001);
            chk("hold_rdy", {31'd0, in_ready}, 32'd0);
        end
        retire;

        // fcvt.wu.h rm=010: unsigned conversion to integer
        fpu_result_rd = 32'hFFFF_FFFF;
        accept(opfp(5'b11000, 5'd1, 3'b010, 5'd4), 16'h7BFF, 16'h0000, 16'h0000, 32'd0);
        chk("cvt_op", {8'd0, fpu_sfpu_op}, 32'h404000);
        chk("cvt_frm", {29'd0, fpu_frm}, 32'd2);
        step;
        step;
        chk("cvt_data", wb_data, 32'hFFFF_FFFF);
        chk("cvt_is_int", {31'd0, wb_is_int}, 32'd1);
        retire;

        // sticky flags: 00001 then 10000 accumulate
        fpu_s_flags = 5'b00001;
        accept(opfp(5'b00001, 5'd2, 3'b000, 5'd1), 16'h3C00, 16'h3C00, 16'h0000, 32'd0);
        step;
        step;
        chk("flg1_wb", {27'd0, wb_flags}, 32'b00001);
        chk("flg1_ff", {27'd0, fflags}, 32'b00001);
        retire;
        fpu_s_flags = 5'b10000;
        accept(opfp(5'b00010, 5'd2, 3'b000, 5'd1), 16'h3C00, 16'h3C00, 16'h0000, 32'd0);
        step;
        step;
        chk("flg2_ff", {27'd0, fflags}, 32'b10001);
        retire;
        // clear on the capture edge: the captured flags win
        accept(opfp(5'b00010, 5'd2, 3'b000, 5'd1), 16'h3C00, 16'h3C00, 16'h0000, 32'd0);
        step;
        csr_fflags_clr = 1'b1;
        step;
        csr_fflags_clr = 1'b0;
        chk("flgclr_ff", {27'd0, fflags}, 32'b10000);
        retire;

        // asynchronous reset in EXEC
        fpu_resultant = 16'h3E00;
        fpu_s_flags   = 5'b00000;
        accept(opfp(5'b00000, 5'd2, 3'b000, 5'd7), 16'h3C00, 16'h3800, 16'h0000, 32'd0);
        chk("pre_rst_op", {8'd0, fpu_sfpu_op}, 32'h000001);
        rst_l = 1'b0;
        #1;
        chk("arst_op", {8'd0, fpu_sfpu_op}, 32'd0);
        chk("arst_a", {16'd0, fpu_op_a}, 32'd0);
        chk("arst_rdy", {31'd0, in_ready}, 32'd1);
        chk("arst_ff", {27'd0, fflags}, 32'd0);
        chk("arst_rd", {27'd0, wb_rd}, 32'd0);
        #2;
        rst_l = 1'b1;
        step;
        chk("post_rst_rdy", {31'd0, in_ready}, 32'd1);
        chk("post_rst_vld", {31'd0, wb_valid}, 32'd0);
        accept(opfp(5'b00000, 5'd2, 3'b000, 5'd7), 16'h3C00, 16'h3800, 16'h0000, 32'd0);
        step;
        step;
        chk("post_rst_data", wb_data, 32'h00003E00);
        chk("post_rst_rd", {27'd0, wb_rd}, 32'd7);
        retire;

        // clear without a capture
        fpu_s_flags = 5'b00010;
        accept(opfp(5'b00000, 5'd2, 3'b000, 5'd1), 16'h3C00, 16'h3C00, 16'h0000, 32'd0);
        step;
        step;
        chk("flg3_ff", {27'd0, fflags}, 32'b00010);
        retire;
        csr_fflags_clr = 1'b1;
        step;
        csr_fflags_clr = 1'b0;
        chk("clr_only_ff", {27'd0, fflags}, 32'd0);
        fpu_s_flags = 5'b00000;

        // fdiv.h depends on the divide/sqrt option
        accept(opfp(5'b00011, 5'd2, 3'b000, 5'd6), 16'h3C00, 16'h4000, 16'h0000, 32'd0);
`ifdef FPU_DIVSQRT_EN
        chk("fdiv_op", {8'd0, fpu_sfpu_op}, 32'h000008);
        step;
        step;
        chk("fdiv_ill", {31'd0, wb_illegal}, 32'd0);
`else
        chk("fdiv_vld", {31'd0, wb_valid}, 32'd1);
        chk("fdiv_ill", {31'd0, wb_illegal}, 32'd1);
`endif
        retire;

        // fclass.h is never legal
        accept(opfp(5'b11100, 5'd0, 3'b001, 5'd3), 16'h3C00, 16'h0000, 16'h0000, 32'd0);
        chk("fclass_vld", {31'd0, wb_valid}, 32'd1);
        chk("fclass_ill", {31'd0, wb_illegal}, 32'd1);
        chk("fclass_int", {31'd0, wb_is_int}, 32'd0);
        retire;

        // fadd with single-precision fmt is illegal
        accept(opfp(5'b00000, 5'd2, 3'b000, 5'd3) & ~32'h0600_0000, 16'h3C00, 16'h3C00, 16'h0000, 32'd0);
        chk("fmt_ill", {31'd0, wb_illegal}, 32'd1);
        chk("fmt_op", {8'd0, fpu_sfpu_op}, 32'd0);
        retire;
        chk("end_rdy", {31'd0, in_ready}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
